// File: rtl/deser_pkg.sv
// Shared types and helpers for the serial-to-parallel front end.
package deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned DESER_WIDTH_DFLT = 3;

    // Ceiling log2, minimum 1; used to size the bit counter.
    function automatic int unsigned deser_clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        for (int i = 1; i < 16; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/deser3_ce.sv
// Framed serial-to-parallel converter: assembles WIDTH bits into D with a one-cycle CE strobe,
// and flags frames cut short by a new SFRAME on ERR.
module deser3_ce
    import deser_pkg::*;
#(
    parameter int unsigned WIDTH     = DESER_WIDTH_DFLT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CK,
    input  logic             CLRN,
    input  logic             SDI,
    input  logic             SVALID,
    input  logic             SFRAME,
    output logic [WIDTH-1:0] D,
    output logic             CE,
    output logic             ERR
);

    localparam int unsigned CW = deser_clog2(WIDTH + 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CW-1:0]    w_cnt_inc;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh_nxt;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] w_d_nxt;
    logic             r_ce;
    logic             r_err;
    logic             w_ce_nxt;
    logic             w_err_nxt;
    logic             w_start;
    logic             w_cont;
    logic             w_take;
    logic             w_done;

    // A framed bit always starts a fresh word, from either state.
    always_comb begin
        w_start   = SVALID && SFRAME;
        w_cont    = SVALID && !SFRAME && (r_state == SHIFT);
        w_take    = w_start || w_cont;
        w_base    = w_start ? '0 : r_sh;
        w_cnt_inc = (w_start ? '0 : r_cnt) + CW'(1);
        if (MSB_FIRST) begin
            w_shifted = (w_base << 1) | WIDTH'(SDI);
        end else begin
            w_shifted = (w_base >> 1) | (WIDTH'(SDI) << (WIDTH - 1));
        end
        w_done = w_take && (w_cnt_inc == CW'(WIDTH));
    end

    always_ff @(posedge CK) begin
        if (!CLRN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_start && !w_done) w_state_nxt = SHIFT;
            SHIFT:   if (w_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_ce_nxt  = w_done;
        w_err_nxt = w_start && (r_state == SHIFT);
        w_d_nxt   = w_done ? w_shifted : r_d;
        w_cnt_nxt = r_cnt;
        w_sh_nxt  = r_sh;
        if (w_done) begin
            w_cnt_nxt = '0;
            w_sh_nxt  = '0;
        end else if (w_take) begin
            w_cnt_nxt = w_cnt_inc;
            w_sh_nxt  = w_shifted;
        end
    end

    always_ff @(posedge CK) begin
        if (!CLRN) begin
            r_cnt <= '0;
            r_sh  <= '0;
            r_d   <= '0;
            r_ce  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_sh  <= w_sh_nxt;
            r_d   <= w_d_nxt;
            r_ce  <= w_ce_nxt;
            r_err <= w_err_nxt;
        end
    end

    assign D   = r_d;
    assign CE  = r_ce;
    assign ERR = r_err;

endmodule
